// File: rtl/seq_divider_4b_if.sv
// rtl/seq_divider_4b_if.sv - start/done handshake and operand/result bundle for seq_divider_4b
interface seq_divider_4b_if #(
  parameter int WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] r;
  logic             dz;

  modport master (
    output start, a, b,
    input  busy, done, q, r, dz
  );

  modport slave (
    input  start, a, b,
    output busy, done, q, r, dz
  );
endinterface

// File: rtl/seq_divider_4b.sv
// rtl/seq_divider_4b.sv - restoring shift-subtract divider, one quotient bit per clock
// Define DIV_SIGNED_EN for two's-complement operands (magnitude divide plus sign fix-up).
module seq_divider_4b #(
  parameter int WIDTH = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  seq_divider_4b_if.slave bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] dq;
  logic [WIDTH-1:0] dvs;
  logic [WIDTH:0]   rem;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] q_reg, r_reg;
  logic             dz_reg;

  logic             accept, last, b_zero;
  logic [WIDTH+1:0] rem_sh, trial;
  logic             take;
  logic [WIDTH:0]   rem_nx;
  logic [WIDTH-1:0] dq_nx;
  logic [WIDTH-1:0] a_mag, b_mag, q_fix, r_fix;

  assign accept = (state == IDLE) && bus.start;
  assign b_zero = (bus.b == '0);
  assign last   = (state == RUN) && (cnt == CW'(WIDTH - 1));

  // Quotient bits shift into dq from the right as dividend bits leave on the left.
  assign rem_sh = {rem, dq[WIDTH-1]};
  assign trial  = rem_sh - {2'b00, dvs};
  assign take   = ~trial[WIDTH+1];
  assign rem_nx = take ? trial[WIDTH:0] : rem_sh[WIDTH:0];
  assign dq_nx  = {dq[WIDTH-2:0], take};

`ifdef DIV_SIGNED_EN
  logic q_neg, r_neg;
  assign a_mag = bus.a[WIDTH-1] ? (~bus.a + WIDTH'(1)) : bus.a;
  assign b_mag = bus.b[WIDTH-1] ? (~bus.b + WIDTH'(1)) : bus.b;
  assign q_fix = q_neg ? (~dq_nx + WIDTH'(1)) : dq_nx;
  assign r_fix = r_neg ? (~rem_nx[WIDTH-1:0] + WIDTH'(1)) : rem_nx[WIDTH-1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_neg <= 1'b0;
      r_neg <= 1'b0;
    end else if (accept) begin
      q_neg <= bus.a[WIDTH-1] ^ bus.b[WIDTH-1];
      r_neg <= bus.a[WIDTH-1];
    end
  end
`else
  assign a_mag = bus.a;
  assign b_mag = bus.b;
  assign q_fix = dq_nx;
  assign r_fix = rem_nx[WIDTH-1:0];
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (bus.start) state_nx = b_zero ? DONE : RUN;
      RUN:     if (last) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dq     <= '0;
      dvs    <= '0;
      rem    <= '0;
      cnt    <= '0;
      q_reg  <= '0;
      r_reg  <= '0;
      dz_reg <= 1'b0;
    end else if (accept) begin
      dq  <= a_mag;
      dvs <= b_mag;
      rem <= '0;
      cnt <= '0;
      // Divide by zero skips RUN, so the result is loaded at accept.
      if (b_zero) begin
        q_reg  <= '1;
        r_reg  <= bus.a;
        dz_reg <= 1'b1;
      end
    end else if (state == RUN) begin
      dq  <= dq_nx;
      rem <= rem_nx;
      cnt <= cnt + CW'(1);
      if (last) begin
        q_reg  <= q_fix;
        r_reg  <= r_fix;
        dz_reg <= 1'b0;
      end
    end
  end

  assign bus.busy = (state == RUN);
  assign bus.done = (state == DONE);
  assign bus.q    = q_reg;
  assign bus.r    = r_reg;
  assign bus.dz   = dz_reg;
endmodule

// File: tb/tb_seq_divider_4b.sv
// tb/tb_seq_divider_4b.sv - directed self-checking bench for seq_divider_4b
module tb_seq_divider_4b;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  seq_divider_4b_if #(.WIDTH(4)) dif ();

  seq_divider_4b #(.WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (dif)
  );

  always #5 clk = ~clk;

  task automatic do_op(input logic [3:0] ta, input logic [3:0] tbv,
                       output int lat, output int bcnt,
                       output logic [3:0] rq, output logic [3:0] rr, output logic rdz);
    @(negedge clk);
    dif.start = 1'b1; dif.a = ta; dif.b = tbv;
    @(posedge clk);
    @(negedge clk);
    dif.start = 1'b0; dif.a = 4'h0; dif.b = 4'h0;
    lat = 1; bcnt = 0;
    while (!dif.done && lat < 20) begin
      if (dif.busy) bcnt++;
      @(negedge clk);
      lat++;
    end
    rq = dif.q; rr = dif.r; rdz = dif.dz;
  endtask

  task automatic test_reset;
    dif.start = 1'b0; dif.a = 4'h0; dif.b = 4'h0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({dif.busy, dif.done, dif.dz} !== 3'b000) begin
      n_err++; $display("FAIL reset_flags: got busy/done/dz=%b required 000", {dif.busy, dif.done, dif.dz});
    end
    n_cmp++;
    if ({dif.q, dif.r} !== 8'h00) begin
      n_err++; $display("FAIL reset_qr: got q=%h r=%h required 0 0", dif.q, dif.r);
    end
  endtask

  task automatic test_basic;
    int lat, bcnt; logic [3:0] q, r; logic dz;
    do_op(4'd13, 4'd3, lat, bcnt, q, r, dz);
    n_cmp++;
    if (lat !== 5) begin n_err++; $display("FAIL basic_latency: got %0d required 5", lat); end
    n_cmp++;
    if (bcnt !== 4) begin n_err++; $display("FAIL basic_busy: got %0d cycles required 4", bcnt); end
    n_cmp++;
    if ({q, r, dz} !== {4'd4, 4'd1, 1'b0}) begin
      n_err++; $display("FAIL basic_13_3: got q=%h r=%h dz=%b required 4 1 0", q, r, dz);
    end
  endtask

  task automatic test_div_zero;
    int lat, bcnt; logic [3:0] q, r; logic dz;
    do_op(4'd7, 4'd0, lat, bcnt, q, r, dz);
    n_cmp++;
    if (lat !== 1) begin n_err++; $display("FAIL dz_latency: got %0d required 1", lat); end
    n_cmp++;
    if ({q, r, dz} !== {4'hF, 4'd7, 1'b1}) begin
      n_err++; $display("FAIL dz_7_0: got q=%h r=%h dz=%b required f 7 1", q, r, dz);
    end
    do_op(4'd6, 4'd2, lat, bcnt, q, r, dz);
    n_cmp++;
    if ({q, r, dz} !== {4'd3, 4'd0, 1'b0}) begin
      n_err++; $display("FAIL dz_clear_6_2: got q=%h r=%h dz=%b required 3 0 0", q, r, dz);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({dif.q, dif.r, dif.dz, dif.done} !== {4'd3, 4'd0, 1'b0, 1'b0}) begin
      n_err++; $display("FAIL hold_after_done: got q=%h r=%h dz=%b done=%b required 3 0 0 0",
                        dif.q, dif.r, dif.dz, dif.done);
    end
  endtask

  task automatic test_patterns;
    logic [3:0] va [5] = '{4'd15, 4'd2, 4'd9, 4'd14, 4'd0};
    logic [3:0] vb [5] = '{4'd1,  4'd9, 4'd9, 4'd5,  4'd7};
    logic [3:0] eq [5] = '{4'd15, 4'd0, 4'd1, 4'd2,  4'd0};
    logic [3:0] er [5] = '{4'd0,  4'd2, 4'd0, 4'd4,  4'd0};
    int lat, bcnt; logic [3:0] q, r; logic dz;
    for (int i = 0; i < 5; i++) begin
      do_op(va[i], vb[i], lat, bcnt, q, r, dz);
      n_cmp++;
      if ({q, r, dz} !== {eq[i], er[i], 1'b0} || lat !== 5) begin
        n_err++;
        $display("FAIL pattern_%0d_%0d: got q=%h r=%h dz=%b lat=%0d required %h %h 0 5",
                 va[i], vb[i], q, r, dz, lat, eq[i], er[i]);
      end
    end
  endtask

  task automatic test_start_held;
    int dones = 0; int first = 0;
    @(negedge clk);
    dif.start = 1'b1; dif.a = 4'd13; dif.b = 4'd3;
    @(posedge clk);
    @(negedge clk);
    dif.a = 4'd15; dif.b = 4'd1;
    for (int c = 1; c <= 12; c++) begin
      if (dif.done) begin
        dones++;
        if (first == 0) first = c;
        dif.start = 1'b0;
      end
      @(negedge clk);
    end
    dif.start = 1'b0;
    n_cmp++;
    if (dones !== 1 || first !== 5) begin
      n_err++; $display("FAIL start_held_done: got %0d pulses first at %0d required 1 at 5", dones, first);
    end
    n_cmp++;
    if ({dif.q, dif.r} !== {4'd4, 4'd1}) begin
      n_err++; $display("FAIL start_held_result: got q=%h r=%h required 4 1", dif.q, dif.r);
    end
  endtask

  task automatic test_back_to_back;
    int lat, bcnt; logic [3:0] q, r; logic dz;
    do_op(4'd11, 4'd4, lat, bcnt, q, r, dz);
    n_cmp++;
    if ({q, r} !== {4'd2, 4'd3}) begin
      n_err++; $display("FAIL b2b_first: got q=%h r=%h required 2 3", q, r);
    end
    dif.start = 1'b1; dif.a = 4'd9; dif.b = 4'd2;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (dif.busy !== 1'b0) begin
      n_err++; $display("FAIL b2b_done_ignores_start: got busy=%b required 0", dif.busy);
    end
    @(posedge clk);
    @(negedge clk);
    dif.start = 1'b0;
    lat = 1;
    while (!dif.done && lat < 20) begin @(negedge clk); lat++; end
    n_cmp++;
    if ({dif.q, dif.r} !== {4'd4, 4'd1} || lat !== 5) begin
      n_err++; $display("FAIL b2b_second: got q=%h r=%h lat=%0d required 4 1 5", dif.q, dif.r, lat);
    end
  endtask

  task automatic test_reset_mid_run;
    int dones = 0;
    @(negedge clk);
    dif.start = 1'b1; dif.a = 4'd13; dif.b = 4'd3;
    @(posedge clk);
    @(negedge clk);
    dif.start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({dif.busy, dif.done, dif.q, dif.r, dif.dz} !== 11'd0) begin
      n_err++; $display("FAIL mid_run_reset: got busy=%b done=%b q=%h r=%h dz=%b required all 0",
                        dif.busy, dif.done, dif.q, dif.r, dif.dz);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (dif.done) dones++;
      @(negedge clk);
    end
    n_cmp++;
    if (dones !== 0 || dif.q !== 4'd0) begin
      n_err++; $display("FAIL mid_run_no_done: got %0d pulses q=%h required 0 0", dones, dif.q);
    end
  endtask

`ifdef DIV_SIGNED_EN
  task automatic test_signed;
    logic [3:0] va [4] = '{4'h9, 4'h8, 4'h7, 4'hA};
    logic [3:0] vb [4] = '{4'h2, 4'hF, 4'hE, 4'h0};
    logic [3:0] eq [4] = '{4'hD, 4'h8, 4'hD, 4'hF};
    logic [3:0] er [4] = '{4'hF, 4'h0, 4'h1, 4'hA};
    logic       ez [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    int lat, bcnt; logic [3:0] q, r; logic dz;
    for (int i = 0; i < 4; i++) begin
      do_op(va[i], vb[i], lat, bcnt, q, r, dz);
      n_cmp++;
      if ({q, r, dz} !== {eq[i], er[i], ez[i]}) begin
        n_err++;
        $display("FAIL signed_%h_%h: got q=%h r=%h dz=%b required %h %h %b",
                 va[i], vb[i], q, r, dz, eq[i], er[i], ez[i]);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_patterns();
    test_start_held();
    test_back_to_back();
    test_reset_mid_run();
`ifdef DIV_SIGNED_EN
    test_signed();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
